// File: rtl/bsram_port_arbiter_if.sv
// ============================================================================
//  Module : bsram_port_arbiter_if
//  Two-requester BSRAM access bus: request/response lanes plus memory side.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

interface bsram_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic [1:0]                 reqValid;
  logic [1:0]                 reqWrite;
  logic [1:0][ADDR_WIDTH-1:0] reqAddr;
  logic [1:0][DATA_WIDTH-1:0] reqWdata;
  logic [1:0]                 reqReady;
  logic [1:0]                 rspValid;
  logic [1:0][DATA_WIDTH-1:0] rspRdata;

  logic                       memReadEn;
  logic [ADDR_WIDTH-1:0]      memReadAddr;
  logic [DATA_WIDTH-1:0]      memReadData;
  logic                       memWriteEn;
  logic [ADDR_WIDTH-1:0]      memWriteAddr;
  logic [DATA_WIDTH-1:0]      memWriteData;
  logic                       initBusy;

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqWdata, memReadData,
    output reqReady, rspValid, rspRdata, memReadEn, memReadAddr,
           memWriteEn, memWriteAddr, memWriteData, initBusy
  );

  modport master (
    output reqValid, reqWrite, reqAddr, reqWdata, memReadData,
    input  reqReady, rspValid, rspRdata, memReadEn, memReadAddr,
           memWriteEn, memWriteAddr, memWriteData, initBusy
  );
endinterface

`default_nettype wire

// File: rtl/bsram_port_arbiter.sv
// ============================================================================
//  Module : bsram_port_arbiter
//  Round-robin sharing of one 1R/1W BSRAM between two requesters, write-first.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module bsram_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  bsram_port_arbiter_if.slave bus
);

  localparam int                DEPTH         = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [0:0]        c_CLEAR       = 1'b0;
  localparam logic [0:0]        c_RUN         = 1'b1;
  localparam logic [0:0]        c_RESET_STATE = CLEAR_ON_RESET ? c_CLEAR : c_RUN;

  logic [0:0]            r_state;
  logic [0:0]            w_nextState;
  logic [ADDR_WIDTH:0]   r_clrCount;
  logic                  r_rdPtr;
  logic                  r_wrPtr;
  logic [1:0]            w_rdCand;
  logic [1:0]            w_wrCand;
  logic [1:0]            w_rdGrant;
  logic [1:0]            w_wrGrant;
  logic                  w_collide;
  logic [1:0]            r_rspValid;
  logic                  r_collide;
  logic [DATA_WIDTH-1:0] r_colData;
  logic [DATA_WIDTH-1:0] r_rspHold [2];
  logic [DATA_WIDTH-1:0] w_rspData;

  assign w_rdCand = bus.reqValid & ~bus.reqWrite;
  assign w_wrCand = bus.reqValid &  bus.reqWrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_RESET_STATE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (r_state == c_CLEAR && r_clrCount == c_LAST_ADDR) begin
      w_nextState = c_RUN;
    end
  end

  always_comb begin
    w_rdGrant        = 2'b00;
    w_wrGrant        = 2'b00;
    bus.memReadEn    = 1'b0;
    bus.memReadAddr  = '0;
    bus.memWriteEn   = 1'b0;
    bus.memWriteAddr = '0;
    bus.memWriteData = '0;
    case (r_state)
      c_CLEAR: begin
        // Gated so the sweep write drops the instant reset asserts.
        bus.memWriteEn   = rst_n;
        bus.memWriteAddr = r_clrCount[ADDR_WIDTH-1:0];
      end
      default: begin
        w_rdGrant = (&w_rdCand) ? (r_rdPtr ? 2'b10 : 2'b01) : w_rdCand;
        w_wrGrant = (&w_wrCand) ? (r_wrPtr ? 2'b10 : 2'b01) : w_wrCand;
        bus.memReadEn    = |w_rdGrant;
        bus.memReadAddr  = w_rdGrant[1] ? bus.reqAddr[1] : bus.reqAddr[0];
        bus.memWriteEn   = |w_wrGrant;
        bus.memWriteAddr = w_wrGrant[1] ? bus.reqAddr[1]  : bus.reqAddr[0];
        bus.memWriteData = w_wrGrant[1] ? bus.reqWdata[1] : bus.reqWdata[0];
      end
    endcase
  end

  assign w_collide    = bus.memReadEn && (r_state == c_RUN) && (|w_wrGrant) &&
                        (bus.memReadAddr == bus.memWriteAddr);
  assign bus.reqReady = w_rdGrant | w_wrGrant;
  assign bus.rspValid = r_rspValid;
  assign bus.initBusy = (r_state == c_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clrCount <= '0;
      r_rdPtr    <= 1'b0;
      r_wrPtr    <= 1'b0;
      r_rspValid <= 2'b00;
      r_collide  <= 1'b0;
      r_colData  <= '0;
      r_rspHold  <= '{default: '0};
    end else begin
      if (r_state == c_CLEAR) begin
        r_clrCount <= r_clrCount + 1'b1;
      end
      // Priority moves to the requester that was not just served.
      if (|w_rdGrant) begin
        r_rdPtr <= w_rdGrant[0];
      end
      if (|w_wrGrant) begin
        r_wrPtr <= w_wrGrant[0];
      end
      r_rspValid <= w_rdGrant;
      r_collide  <= w_collide;
      if (w_collide) begin
        r_colData <= bus.memWriteData;
      end
      for (int n = 0; n < 2; n++) begin
        if (r_rspValid[n]) begin
          r_rspHold[n] <= w_rspData;
        end
      end
    end
  end

  // The BSRAM returns pre-write data on a same-cycle collision; substitute the write.
  assign w_rspData = r_collide ? r_colData : bus.memReadData;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_rsp
      assign bus.rspRdata[g] = r_rspValid[g] ? w_rspData : r_rspHold[g];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bsram_port_arbiter.sv
// ============================================================================
//  Module : tb_bsram_port_arbiter
//  Random and directed traffic against a transaction-level arbiter/memory model.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bsram_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bsram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bsram_port_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // BSRAM stand-in: registered read that returns the old word on a collision.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.memWriteEn) mem[bus.memWriteAddr] <= bus.memWriteData;
    if (bus.memReadEn)  bus.memReadData <= mem[bus.memReadAddr];
  end

  int total = 0;
  int bad   = 0;

  // Requester state: what each requester is currently presenting.
  bit          rqV [2];
  bit          rqW [2];
  logic [AW-1:0] rqA [2];
  logic [DW-1:0] rqD [2];

  // Reference model state.
  int          clrIdx;
  bit          lastRd, lastWr;          // requester most recently served per port
  bit   [1:0]  pendV;
  logic [DW-1:0] pendD [2];
  logic [DW-1:0] holdD [2];
  logic [DW-1:0] refMem [DEPTH];
  bit   [1:0]  mAcc;

  // Samples of DUT outputs from the last check.
  logic [1:0]    sRdy, sRspV;
  logic [DW-1:0] sRspD [2];
  logic [AW-1:0] sWa;
  logic          sBusy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit [1:0] c, input bit last);
    if (c == 2'b11) return last ? 0 : 1;
    if (c == 2'b01) return 0;
    if (c == 2'b10) return 1;
    return -1;
  endfunction

  task automatic resetModel();
    clrIdx = 0;
    lastRd = 1'b1;
    lastWr = 1'b1;
    pendV  = 2'b00;
    mAcc   = 2'b00;
    holdD[0] = '0;
    holdD[1] = '0;
  endtask

  task automatic check();
    bit [1:0] rc, wc, er;
    int rw, ww;
    sRdy  = bus.reqReady;
    sRspV = bus.rspValid;
    sRspD[0] = bus.rspRdata[0];
    sRspD[1] = bus.rspRdata[1];
    sWa   = bus.memWriteAddr;
    sBusy = bus.initBusy;
    for (int n = 0; n < 2; n++) begin
      chk("rspValid", 64'(bus.rspValid[n]), 64'(pendV[n]));
      chk("rspRdata", 64'(bus.rspRdata[n]), 64'(pendV[n] ? pendD[n] : holdD[n]));
      if (pendV[n]) holdD[n] = pendD[n];
    end
    pendV = 2'b00;
    mAcc  = 2'b00;
    if (clrIdx < DEPTH) begin
      chk("clr initBusy", 64'(bus.initBusy), 64'd1);
      chk("clr ready",    64'(bus.reqReady), 64'd0);
      chk("clr rdEn",     64'(bus.memReadEn), 64'd0);
      chk("clr wrEn",     64'(bus.memWriteEn), 64'd1);
      chk("clr wrAddr",   64'(bus.memWriteAddr), 64'(clrIdx));
      chk("clr wrData",   64'(bus.memWriteData), 64'd0);
      refMem[clrIdx] = '0;
      clrIdx++;
    end else begin
      for (int n = 0; n < 2; n++) begin
        rc[n] = rqV[n] && !rqW[n];
        wc[n] = rqV[n] &&  rqW[n];
      end
      rw = pick(rc, lastRd);
      ww = pick(wc, lastWr);
      er = 2'b00;
      if (rw >= 0) er[rw] = 1'b1;
      if (ww >= 0) er[ww] = 1'b1;
      chk("run initBusy", 64'(bus.initBusy), 64'd0);
      chk("run ready",    64'(bus.reqReady), 64'(er));
      chk("run rdEn",     64'(bus.memReadEn), 64'(rw >= 0));
      chk("run wrEn",     64'(bus.memWriteEn), 64'(ww >= 0));
      if (rw >= 0) chk("run rdAddr", 64'(bus.memReadAddr), 64'(rqA[rw]));
      if (ww >= 0) begin
        chk("run wrAddr", 64'(bus.memWriteAddr), 64'(rqA[ww]));
        chk("run wrData", 64'(bus.memWriteData), 64'(rqD[ww]));
      end
      if (rw >= 0) begin
        pendV[rw] = 1'b1;
        pendD[rw] = (ww >= 0 && rqA[ww] == rqA[rw]) ? rqD[ww] : refMem[rqA[rw]];
        lastRd    = rw[0];
      end
      if (ww >= 0) begin
        refMem[rqA[ww]] = rqD[ww];
        lastWr = ww[0];
      end
      mAcc = er;
    end
  endtask

  // Called just after a rising edge: present inputs, check mid-cycle, advance.
  task automatic cyc();
    for (int n = 0; n < 2; n++) begin
      bus.reqValid[n] = rqV[n];
      bus.reqWrite[n] = rqW[n];
      bus.reqAddr[n]  = rqA[n];
      bus.reqWdata[n] = rqD[n];
    end
    @(negedge clk);
    check();
    for (int n = 0; n < 2; n++) if (mAcc[n]) rqV[n] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int n, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rqV[n] = 1'b1; rqW[n] = w; rqA[n] = a; rqD[n] = d;
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      rqV[n] = 1'b0; rqW[n] = 1'b0; rqA[n] = '0; rqD[n] = '0;
      bus.reqValid[n] = 1'b0; bus.reqWrite[n] = 1'b0;
      bus.reqAddr[n]  = '0;   bus.reqWdata[n] = '0;
    end
    resetModel();

    // Reset values
    @(negedge clk);
    chk("reset initBusy", 64'(bus.initBusy), 64'd1);
    chk("reset wrEn",     64'(bus.memWriteEn), 64'd0);
    chk("reset rdEn",     64'(bus.memReadEn), 64'd0);
    chk("reset ready",    64'(bus.reqReady), 64'd0);
    chk("reset rspValid", 64'(bus.rspValid), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Clear sweep with a write held pending throughout
    setReq(0, 1'b1, 4'd5, 32'h12345678);
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      chk("t1 sweep addr", 64'(sWa), 64'(i));
      chk("t1 sweep ready", 64'(sRdy), 64'd0);
    end
    cyc();
    chk("t1 busy fell", 64'(sBusy), 64'd0);
    chk("t1 held write ready", 64'(sRdy), 64'b01);

    // Single read
    setReq(0, 1'b0, 4'd5, '0);
    cyc();
    chk("t2 ready", 64'(sRdy), 64'b01);
    cyc();
    chk("t2 rspValid", 64'(sRspV), 64'b01);
    chk("t2 rdata", 64'(sRspD[0]), 64'h12345678);
    cyc();
    chk("t2 rspValid gone", 64'(sRspV), 64'b00);

    // Contending reads alternate; req1 has priority after req0's read
    for (int i = 0; i < 6; i++) begin
      for (int n = 0; n < 2; n++) if (!rqV[n]) setReq(n, 1'b0, 4'(i), '0);
      cyc();
      chk("t3 grant", 64'(sRdy), (i % 2 == 0) ? 64'b10 : 64'b01);
      if (i > 0) chk("t3 rsp", 64'(sRspV), (i % 2 == 0) ? 64'b01 : 64'b10);
    end
    cyc();
    chk("t3 drain grant", 64'(sRdy), 64'b10);

    // Write/read collision, write-first
    setReq(0, 1'b1, 4'd7, 32'hDEADBEEF);
    setReq(1, 1'b0, 4'd7, '0);
    cyc();
    chk("t4 both ready", 64'(sRdy), 64'b11);
    cyc();
    chk("t4 rspValid", 64'(sRspV), 64'b10);
    chk("t4 rdata", 64'(sRspD[1]), 64'hDEADBEEF);

    // Move write priority to req0, then two writes to one address
    setReq(1, 1'b1, 4'd3, 32'h55);
    cyc();
    setReq(0, 1'b1, 4'd3, 32'hA);
    setReq(1, 1'b1, 4'd3, 32'hB);
    cyc();
    chk("t5 first grant", 64'(sRdy), 64'b01);
    cyc();
    chk("t5 second grant", 64'(sRdy), 64'b10);
    setReq(0, 1'b0, 4'd3, '0);
    cyc();
    cyc();
    chk("t5 readback", 64'(sRspD[0]), 64'hB);

    // Random traffic, addresses biased low to provoke collisions
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!rqV[n] && $urandom_range(0, 99) < 75) begin
          setReq(n, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15)),
                 $urandom);
        end
      end
      cyc();
    end
    for (int c = 0; c < 4 && (rqV[0] || rqV[1]); c++) cyc();
    chk("drain pending", 64'({rqV[1], rqV[0]}), 64'd0);

    // Reset from RUN, then abort the new sweep at address 9
    rst_n = 1'b0;
    #1 resetModel();
    @(posedge clk); #1 rst_n = 1'b1;
    while (clrIdx < 9) cyc();
    @(negedge clk);
    check();
    chk("t6 at addr 9", 64'(sWa), 64'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 wrEn in reset", 64'(bus.memWriteEn), 64'd0);
    chk("t6 wrAddr in reset", 64'(bus.memWriteAddr), 64'd0);
    chk("t6 busy in reset", 64'(bus.initBusy), 64'd1);
    chk("t6 rspValid in reset", 64'(bus.rspValid), 64'd0);
    resetModel();
    @(posedge clk); #1 rst_n = 1'b1;
    cyc();
    chk("t6 restart addr", 64'(sWa), 64'd0);
    for (int c = 0; c < 300; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!rqV[n] && $urandom_range(0, 99) < 60) begin
          setReq(n, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        end
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
